// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver.
// Armed by the command transmitter after it has released the CMD line. The receiver
// hunts for the response start bit within NCR_MAX SD clocks. It then shifts in a
// 48-bit or 136-bit frame and checks CRC7, the transmission bit and the end bit.
// Decoded fields are presented with a single-cycle done pulse.

module sd_cmd_resp_rx #(
  parameter int unsigned NCR_MAX = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_en,
  input  logic         cmd_in,
  input  logic         start,
  input  logic         long_resp,
  input  logic         check_crc,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic         frame_err,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data
);

  typedef enum logic [1:0] {StIdle, StWait, StRecv} state_e;

  // 135 bits are enough: the long-frame start bit is never looked at again.
  localparam int unsigned ShiftW = 135;

  state_e              state_q, state_d;
  logic                long_q, long_d;
  logic                chk_q, chk_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic [6:0]          crc_q, crc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                crc_err_q, crc_err_d;
  logic                frame_err_q, frame_err_d;
  logic [5:0]          index_q, index_d;
  logic [127:0]        data_q, data_d;

  logic [ShiftW-1:0]   shift_nxt;
  logic [CNT_W-1:0]    last_bit;
  logic [CNT_W-1:0]    crc_lo;
  logic [CNT_W-1:0]    crc_hi;
  logic                crc_win;
  logic                tx_bit;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Frame geometry helpers: bit_cnt_q is the index (in arrival order) of the bit
  // being sampled, so the CRC window and the final bit are expressed in that order.
  always_comb begin
    shift_nxt = {shift_q[ShiftW-2:0], cmd_in};
    last_bit  = long_q ? CNT_W'(135) : CNT_W'(47);
    // Long frames skip the start, transmission and 6 reserved bits.
    crc_lo    = long_q ? CNT_W'(8)   : CNT_W'(0);
    crc_hi    = long_q ? CNT_W'(127) : CNT_W'(39);
    crc_win   = (bit_cnt_q >= crc_lo) && (bit_cnt_q <= crc_hi);
    // Transmission bit is the second bit on the wire for either length.
    tx_bit    = long_q ? shift_nxt[134] : shift_nxt[46];
  end

  // Next-state logic and result evaluation.
  always_comb begin
    state_d     = state_q;
    long_d      = long_q;
    chk_d       = chk_q;
    tmo_cnt_d   = tmo_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    index_d     = index_q;
    data_d      = data_q;

    unique case (state_q)
      StIdle: begin
        // A coincident sample_en is deliberately dropped: the line is not yet ours.
        if (start) begin
          long_d      = long_resp;
          chk_d       = check_crc;
          timeout_d   = 1'b0;
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
          index_d     = '0;
          data_d      = '0;
          crc_d       = '0;
          shift_d     = '0;
          bit_cnt_d   = '0;
          tmo_cnt_d   = CNT_W'(NCR_MAX);
          busy_d      = 1'b1;
          state_d     = StWait;
        end
      end

      StWait: begin
        if (sample_en) begin
          if (!cmd_in) begin
            // Start bit is frame bit 0 in arrival order; short-frame CRC covers it.
            shift_d   = {shift_q[ShiftW-2:0], 1'b0};
            bit_cnt_d = CNT_W'(1);
            if (!long_q) begin
              crc_d = crc7_step(crc_q, 1'b0);
            end
            state_d = StRecv;
          end else if (tmo_cnt_q <= CNT_W'(1)) begin
            tmo_cnt_d = '0;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = StIdle;
          end else begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
          end
        end
      end

      StRecv: begin
        if (sample_en) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (crc_win) begin
            crc_d = crc7_step(crc_q, cmd_in);
          end
          if (bit_cnt_q == last_bit) begin
            // The CRC window closes well before the end bit, so crc_q is final here.
            crc_err_d   = chk_q & (crc_q != shift_nxt[7:1]);
            frame_err_d = tx_bit | ~shift_nxt[0];
            if (long_q) begin
              index_d = shift_nxt[133:128];
              data_d  = shift_nxt[127:0];
            end else begin
              index_d = shift_nxt[45:40];
              data_d  = {96'b0, shift_nxt[39:8]};
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      long_q      <= 1'b0;
      chk_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      crc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      index_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      long_q      <= long_d;
      chk_q       <= chk_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      index_q     <= index_d;
      data_q      <= data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign crc_err    = crc_err_q;
  assign frame_err  = frame_err_q;
  assign resp_index = index_q;
  assign resp_data  = data_q;

endmodule
